// File: rtl/register_tree_pkg.sv
// Shared types and sizing helpers for the register-tree priority queue.
package register_tree_pkg;

  typedef enum logic [1:0] {IDLE, SWAP_EVEN, SWAP_ODD, OP} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_ENQ, CMD_DEQ, CMD_REP} cmd_t;

  function automatic int tree_depth(input int queue_size);
    return $clog2(queue_size + 1);
  endfunction

  function automatic int tree_nodes(input int queue_size);
    return (1 << tree_depth(queue_size)) - 1;
  endfunction

  // Level of a node in a 0-rooted binary tree: floor(log2(idx+1)).
  function automatic int node_level(input int idx);
    return $clog2(idx + 2) - 1;
  endfunction

endpackage

// File: rtl/register_tree_node_cmp.sv
// Three-way compare-swap of a parent node against its two children.
module register_tree_node_cmp #(
  parameter int DATA_WIDTH = 16,
  parameter bit MIN_HEAP   = 1'b0
) (
  input  logic [DATA_WIDTH:0] parent_in,
  input  logic [DATA_WIDTH:0] left_in,
  input  logic [DATA_WIDTH:0] right_in,
  output logic [DATA_WIDTH:0] parent_out,
  output logic [DATA_WIDTH:0] left_out,
  output logic [DATA_WIDTH:0] right_out
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } node_t;

  node_t p, l, r;

  assign p = parent_in;
  assign l = left_in;
  assign r = right_in;

  // Strict "a outranks b": an invalid node never wins, ties never win.
  function automatic logic beats(input node_t a, input node_t b);
    if (!a.valid) return 1'b0;
    if (!b.valid) return 1'b1;
    return MIN_HEAP ? (a.data < b.data) : (a.data > b.data);
  endfunction

  always_comb begin
    parent_out = parent_in;
    left_out   = left_in;
    right_out  = right_in;
    if (beats(r, p) && beats(r, l)) begin
      parent_out = right_in;
      right_out  = parent_in;
    end else if (beats(l, p)) begin
      parent_out = left_in;
      left_out   = parent_in;
    end
  end

endmodule

// File: rtl/register_tree_pq.sv
// Priority queue held as a heap-ordered array of node registers, sorted by
// comparators that alternate between even and odd parent levels.
module register_tree_pq
  import register_tree_pkg::*;
#(
  parameter int QUEUE_SIZE = 15,
  parameter int DATA_WIDTH = 16,
  parameter bit MIN_HEAP   = 1'b0
) (
  input  logic                            i_CLK,
  input  logic                            i_RST,
  input  logic                            i_wrt,
  input  logic                            i_read,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_valid,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic                            o_err
);

  localparam int NODES    = tree_nodes(QUEUE_SIZE);
  localparam int INTERNAL = NODES / 2;
  localparam int CNT_W    = $clog2(QUEUE_SIZE + 1);
  localparam int IDX_W    = $clog2(NODES);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } node_t;

  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      count_q, count_d;
  node_t                 tree_q  [NODES];
  node_t                 tree_d  [NODES];
  node_t                 swapped [NODES];
  logic [DATA_WIDTH:0]   cmp_p   [INTERNAL];
  logic [DATA_WIDTH:0]   cmp_l   [INTERNAL];
  logic [DATA_WIDTH:0]   cmp_r   [INTERNAL];
  logic                  swap_en [INTERNAL];
  logic [IDX_W-1:0]      free_idx;
  logic                  full, empty;

  assign full  = (count_q == CNT_W'(QUEUE_SIZE));
  assign empty = (count_q == '0);

  // Comparators on the same level parity never share a node, so each
  // phase can swap all of them at once.
  for (genvar p = 0; p < INTERNAL; p++) begin : g_cmp
    localparam bit ODD_LEVEL = (node_level(p) % 2) == 1;

    assign swap_en[p] = ODD_LEVEL ? (state_q == SWAP_ODD) : (state_q == SWAP_EVEN);

    register_tree_node_cmp #(
      .DATA_WIDTH(DATA_WIDTH),
      .MIN_HEAP  (MIN_HEAP)
    ) u_cmp (
      .parent_in (tree_q[p]),
      .left_in   (tree_q[2*p+1]),
      .right_in  (tree_q[2*p+2]),
      .parent_out(cmp_p[p]),
      .left_out  (cmp_l[p]),
      .right_out (cmp_r[p])
    );
  end

  always_comb begin
    for (int i = 0; i < NODES; i++) swapped[i] = tree_q[i];
    for (int p = 0; p < INTERNAL; p++) begin
      if (swap_en[p]) begin
        swapped[p]     = cmp_p[p];
        swapped[2*p+1] = cmp_l[p];
        swapped[2*p+2] = cmp_r[p];
      end
    end
  end

  // Lowest-index hole within the usable capacity.
  always_comb begin
    free_idx = '0;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (!tree_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = CMD_NONE;
    data_d  = data_q;
    count_d = count_q;
    for (int i = 0; i < NODES; i++) tree_d[i] = swapped[i];
    case (state_q)
      OP: begin
        state_d = SWAP_EVEN;
        case (cmd_q)
          CMD_ENQ: begin
            if (!full) begin
              tree_d[free_idx] = '{valid: 1'b1, data: data_q};
              count_d          = count_q + CNT_W'(1);
            end
          end
          CMD_DEQ: begin
            if (!empty) begin
              tree_d[0].valid = 1'b0;
              count_d         = count_q - CNT_W'(1);
            end
          end
          CMD_REP: begin
            tree_d[0] = '{valid: 1'b1, data: data_q};
            if (empty) count_d = CNT_W'(1);
          end
          default: ;
        endcase
      end
      default: begin
        if (i_wrt || i_read) begin
          state_d = OP;
          data_d  = i_data;
          cmd_d   = i_wrt ? (i_read ? CMD_REP : CMD_ENQ) : CMD_DEQ;
        end else begin
          state_d = (state_q == SWAP_EVEN) ? SWAP_ODD : SWAP_EVEN;
        end
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NONE;
      data_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NODES; i++) tree_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      count_q <= count_d;
      for (int i = 0; i < NODES; i++) tree_q[i] <= tree_d[i];
    end
  end

  assign o_valid = tree_q[0].valid;
  assign o_data  = tree_q[0].valid ? tree_q[0].data : '0;
  assign o_count = count_q;
  assign o_full  = full;
  assign o_empty = empty;
  assign o_err   = (state_q == OP) &&
                   (((cmd_q == CMD_ENQ) && full) || ((cmd_q == CMD_DEQ) && empty));

endmodule

// File: tb/tb_register_tree_pq.sv
// Randomised and directed bench: a max-heap of 15 and a min-heap of 5,
// both compared every cycle against a multiset model of the queue.
module tb_register_tree_pq;

  localparam int DW        = 16;
  localparam int CAP[2]    = '{15, 5};
  localparam bit MINH[2]   = '{1'b0, 1'b1};
  localparam int SETTLE[2] = '{120, 56};

  logic          clk = 1'b0;
  logic          rst;
  logic          wrt   [2];
  logic          rd    [2];
  logic [DW-1:0] din   [2];
  logic [DW-1:0] dout  [2];
  logic          vld   [2];
  logic          full  [2];
  logic          empty [2];
  logic          err   [2];
  logic [3:0]    cnt0;
  logic [2:0]    cnt1;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  int mval [2][16];
  int mcnt [2];
  bit busy [2];
  bit pw   [2];
  bit pr   [2];
  int pdata [2];
  bit exp_err [2];
  int idle_cnt [2];

  always #5 clk = ~clk;

  register_tree_pq #(.QUEUE_SIZE(15), .DATA_WIDTH(DW), .MIN_HEAP(1'b0)) u_dut0 (
    .i_CLK(clk), .i_RST(rst), .i_wrt(wrt[0]), .i_read(rd[0]), .i_data(din[0]),
    .o_data(dout[0]), .o_valid(vld[0]), .o_full(full[0]), .o_empty(empty[0]),
    .o_count(cnt0), .o_err(err[0])
  );

  register_tree_pq #(.QUEUE_SIZE(5), .DATA_WIDTH(DW), .MIN_HEAP(1'b1)) u_dut1 (
    .i_CLK(clk), .i_RST(rst), .i_wrt(wrt[1]), .i_read(rd[1]), .i_data(din[1]),
    .o_data(dout[1]), .o_valid(vld[1]), .o_full(full[1]), .o_empty(empty[1]),
    .o_count(cnt1), .o_err(err[1])
  );

  function automatic logic [31:0] dut_count(input int d);
    return (d == 0) ? {28'd0, cnt0} : {29'd0, cnt1};
  endfunction

  function automatic int best_idx(input int d);
    int bi = 0;
    for (int i = 1; i < mcnt[d]; i++) begin
      if (MINH[d] ? (mval[d][i] < mval[d][bi]) : (mval[d][i] > mval[d][bi])) bi = i;
    end
    return bi;
  endfunction

  function automatic int model_head(input int d);
    if (mcnt[d] == 0) return 0;
    return mval[d][best_idx(d)];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Queue semantics: a command is taken when the queue is not busy and acts
  // one edge later; anything presented while busy is dropped.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mcnt[d]     = 0;
        busy[d]     = 1'b0;
        exp_err[d]  = 1'b0;
        idle_cnt[d] = SETTLE[d];
      end else if (busy[d]) begin
        busy[d]     = 1'b0;
        exp_err[d]  = 1'b0;
        idle_cnt[d] = 0;
        if (pw[d] && !pr[d]) begin
          if (mcnt[d] < CAP[d]) begin
            mval[d][mcnt[d]] = pdata[d];
            mcnt[d]++;
          end
        end else if (!pw[d] && pr[d]) begin
          if (mcnt[d] > 0) begin
            mval[d][best_idx(d)] = mval[d][mcnt[d]-1];
            mcnt[d]--;
          end
        end else begin
          if (mcnt[d] == 0) begin
            mval[d][0] = pdata[d];
            mcnt[d]    = 1;
          end else begin
            mval[d][best_idx(d)] = pdata[d];
          end
        end
      end else begin
        if (idle_cnt[d] < 100000) idle_cnt[d]++;
        if (wrt[d] || rd[d]) begin
          busy[d]    = 1'b1;
          pw[d]      = wrt[d];
          pr[d]      = rd[d];
          pdata[d]   = int'(din[d]);
          exp_err[d] = (wrt[d] && !rd[d] && mcnt[d] == CAP[d]) ||
                       (!wrt[d] && rd[d] && mcnt[d] == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("dut%0d count", d), dut_count(d), mcnt[d]);
        checkOutput($sformatf("dut%0d full", d), {31'd0, full[d]}, (mcnt[d] == CAP[d]) ? 1 : 0);
        checkOutput($sformatf("dut%0d empty", d), {31'd0, empty[d]}, (mcnt[d] == 0) ? 1 : 0);
        checkOutput($sformatf("dut%0d err", d), {31'd0, err[d]}, {31'd0, exp_err[d]});
        if (vld[d] === 1'b0) checkOutput($sformatf("dut%0d data_when_invalid", d), {16'd0, dout[d]}, 0);
        if (idle_cnt[d] >= SETTLE[d]) begin
          checkOutput($sformatf("dut%0d valid", d), {31'd0, vld[d]}, (mcnt[d] > 0) ? 1 : 0);
          checkOutput($sformatf("dut%0d head", d), {16'd0, dout[d]}, model_head(d));
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  // Presents one command for a single cycle; call just after a rising edge.
  task automatic applyStimulus(input int d, input bit w, input bit r, input logic [DW-1:0] v);
    wrt[d] = w;
    rd[d]  = r;
    din[d] = v;
    sync();
    wrt[d] = 1'b0;
    rd[d]  = 1'b0;
    din[d] = '0;
  endtask

  int heads[4] = '{9, 5, 3, 0};
  int enq_vals[4] = '{5, 9, 0, 3};
  int rsel;
  logic [DW-1:0] rval;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      wrt[d] = 1'b0;
      rd[d]  = 1'b0;
      din[d] = '0;
    end
    idle(2);
    checking = 1'b1;
    @(negedge clk);
    checkOutput("reset count", dut_count(0), 0);
    checkOutput("reset empty", {31'd0, empty[0]}, 1);
    checkOutput("reset valid", {31'd0, vld[0]}, 0);
    checkOutput("reset data", {16'd0, dout[0]}, 0);
    checkOutput("reset full", {31'd0, full[0]}, 0);
    checkOutput("reset err", {31'd0, err[0]}, 0);
    sync();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 1'b0, DW'(enq_vals[i]));
      idle(3);
    end
    idle(8);
    @(negedge clk);
    checkOutput("enq count", dut_count(0), 4);
    checkOutput("enq head", {16'd0, dout[0]}, 9);
    checkOutput("enq valid", {31'd0, vld[0]}, 1);
    checkOutput("model head pin", model_head(0), 9);
    checkOutput("model count pin", mcnt[0], 4);
    sync();

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("deq%0d head", i), {16'd0, dout[0]}, heads[i]);
      checkOutput($sformatf("deq%0d head valid", i), {31'd0, vld[0]}, 1);
      sync();
      applyStimulus(0, 1'b0, 1'b1, '0);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("deq%0d gap", i), {31'd0, vld[0]}, 0);
      @(negedge clk);
      checkOutput($sformatf("deq%0d refill", i), {31'd0, vld[0]}, (i < 3) ? 1 : 0);
      sync();
      idle(8);
    end
    @(negedge clk);
    checkOutput("drained empty", {31'd0, empty[0]}, 1);
    checkOutput("drained valid", {31'd0, vld[0]}, 0);
    checkOutput("drained data", {16'd0, dout[0]}, 0);
    sync();

    applyStimulus(0, 1'b0, 1'b1, '0);
    @(negedge clk);
    checkOutput("empty deq err", {31'd0, err[0]}, 1);
    @(negedge clk);
    checkOutput("empty deq err end", {31'd0, err[0]}, 0);
    checkOutput("empty deq count", dut_count(0), 0);
    sync();
    idle(2);
    applyStimulus(0, 1'b1, 1'b1, 16'h00AA);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rep empty count", dut_count(0), 1);
    checkOutput("rep empty data", {16'd0, dout[0]}, 32'h00AA);
    checkOutput("rep empty valid", {31'd0, vld[0]}, 1);
    sync();

    for (int v = 1; v <= 5; v++) begin
      applyStimulus(1, 1'b1, 1'b0, DW'(v));
      idle(1);
    end
    applyStimulus(1, 1'b1, 1'b0, 16'd7);
    @(negedge clk);
    checkOutput("full enq err", {31'd0, err[1]}, 1);
    @(negedge clk);
    checkOutput("full enq count", dut_count(1), 5);
    checkOutput("full flag", {31'd0, full[1]}, 1);
    sync();
    idle(SETTLE[1]);
    @(negedge clk);
    checkOutput("min head after fill", {16'd0, dout[1]}, 1);
    checkOutput("model min head pin", model_head(1), 1);
    sync();
    repeat (5) begin
      applyStimulus(1, 1'b0, 1'b1, '0);
      idle(10);
    end
    applyStimulus(1, 1'b1, 1'b0, 16'd4);
    idle(1);
    applyStimulus(1, 1'b1, 1'b0, 16'd2);
    idle(1);
    applyStimulus(1, 1'b1, 1'b0, 16'd8);
    idle(20);
    @(negedge clk);
    checkOutput("min head 2", {16'd0, dout[1]}, 2);
    sync();
    applyStimulus(1, 1'b1, 1'b1, 16'd6);
    idle(20);
    @(negedge clk);
    checkOutput("min rep head", {16'd0, dout[1]}, 4);
    checkOutput("min rep count", dut_count(1), 3);
    sync();

    applyStimulus(0, 1'b1, 1'b0, 16'h0011);
    idle(2);
    applyStimulus(0, 1'b1, 1'b0, 16'h0022);
    idle(2);
    @(negedge clk);
    checkOutput("pre reset count", dut_count(0), 3);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid reset count", dut_count(0), 0);
    checkOutput("mid reset valid", {31'd0, vld[0]}, 0);
    checkOutput("mid reset data", {16'd0, dout[0]}, 0);
    checkOutput("mid reset empty", {31'd0, empty[0]}, 1);
    checkOutput("mid reset err", {31'd0, err[0]}, 0);
    sync();
    applyStimulus(0, 1'b1, 1'b0, 16'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("post reset head", {16'd0, dout[0]}, 1);
    checkOutput("post reset valid", {31'd0, vld[0]}, 1);
    sync();

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        rsel = $urandom_range(0, 9);
        rval = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 31));
        if (rsel < 5) begin
          applyStimulus(d, 1'b1, 1'b0, rval);
        end else begin
          idle(SETTLE[d]);
          applyStimulus(d, rsel >= 8, 1'b1, rval);
        end
        idle($urandom_range(0, 2));
      end
      idle(SETTLE[d] + 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_tree_pq.md
# register_tree_pq

Parametrised register-tree priority queue: a flat array of tree-ordered node registers, each with a valid bit, kept heap-ordered by per-node three-way comparators that fire on even and odd tree levels in alternating cycles. Unlike the first-generation tree, it has the following features:
- Zero is a legal payload.
- Capacity need not be 2^n−1.
- Max-heap or min-heap is selectable.
- Errors are flagged.
- The head is qualified by a valid output.

It sits between a producer issuing enqueue/dequeue/replace commands and a consumer reading the current head.

## Interface
- QUEUE_SIZE, 15: usable capacity, ≥2; any value (not only 2^n−1).
- DATA_WIDTH, 16: payload width, ≥1.
- MIN_HEAP, 0: 0 = root holds largest value; 1 = root holds smallest.
- i_CLK  in  1  single clock; all state on rising edge.
- i_RST  in  1  reset, synchronous, active-high.
- i_wrt  in  1  enqueue request (replace when paired with i_read).
- i_read  in  1  dequeue request (replace when paired with i_wrt).
- i_data  in  DATA_WIDTH  payload for enqueue/replace.
- o_data  out  DATA_WIDTH  root payload; 0 when o_valid low.
- o_valid  out  1  root node holds a valid entry.
- o_full  out  1  count == QUEUE_SIZE.
- o_empty  out  1  count == 0.
- o_count  out  $clog2(QUEUE_SIZE+1)  occupied entries.
- o_err  out  1  one-cycle pulse on a rejected command.

## Operation
- DEPTH = $clog2(QUEUE_SIZE+1); NODES = 2^DEPTH−1; node i has children 2i+1 and 2i+2.
- Each node stores {valid, data}.
- Only indices < QUEUE_SIZE are ever written valid.
- Priority compare (MIN_HEAP=0): a valid node beats an invalid one; between two valid nodes, the larger value wins. MIN_HEAP=1 inverts the value compare only.
- Ties keep the parent; between equal children, the left child wins.
- Comparator at parent p: the winner of {p, L, R} moves to p, and the displaced parent takes the winner's slot. Invalid children are never promoted.
- FSM states:
  - IDLE (after reset)
  - SWAP_EVEN (comparators whose parent level is 0, 2, 4, …)
  - SWAP_ODD (parent levels 1, 3, …)
  - OP
- Transitions:
  - Any command (i_wrt or i_read high) in IDLE, SWAP_EVEN or SWAP_ODD → OP.
  - Otherwise IDLE → SWAP_EVEN, SWAP_EVEN → SWAP_ODD, SWAP_ODD → SWAP_EVEN.
  - OP → SWAP_EVEN unconditionally. A command presented while in OP is ignored; no count change, no o_err.
- Commands are sampled in the cycle they are presented (not in OP) and execute in the following OP cycle; no swaps occur in OP.
  - Enqueue (wrt & !read): if not full, write {1, i_data} to the lowest-index invalid node below QUEUE_SIZE and increment count. If full, drop the command and pulse o_err.
  - Dequeue (!wrt & read): if not empty, clear the root valid bit and decrement count. If empty, pulse o_err.
  - Replace (wrt & read): overwrite the root with {1, i_data}. If empty, count becomes 1; otherwise count is unchanged. No error.
- The count is registered alongside the command, so o_full, o_empty and o_count update at the same edge as the node array.

## Timing
- Reset (i_RST high at an edge):
  - All valid bits and data are cleared; count is 0; state is IDLE.
  - Outputs: o_data=0, o_valid=0, o_empty=1, o_full=0, o_count=0, o_err=0.
  - Reset mid-operation discards all contents with no residual pulse.
- o_data and o_valid are driven combinationally from the root register. The enqueue/replace result is visible one cycle after the OP edge.
- After a dequeue, o_valid is low for exactly one cycle (OP→SWAP_EVEN refills the root) whenever the remaining count > 0.
- After an enqueue into an otherwise ordered tree, the root is correct within 2·(DEPTH−1) swap cycles.
- o_err is asserted during the OP cycle of the rejected command.

## Structure
- Package register_tree_pkg holds:
  - state_t enum (IDLE, SWAP_EVEN, SWAP_ODD, OP)
  - node_t packed struct {valid, data}, parametrised via the module and a typedef in the module scope
  - tree_depth() and tree_nodes() constant functions
- Sub-module register_tree_node_cmp: a combinational three-way compare-swap on node_t with a MIN_HEAP parameter. It is instantiated once per internal node (NODES/2 instances).

## Test plan
- Reset, then enqueue 5, 9, 0, 3 (one per 4 idle cycles), MIN_HEAP=0 → o_count=4, and after settling o_data=9, o_valid=1. A zero payload is stored and counted.
- From that state, four dequeues spaced by 2·DEPTH cycles → heads 9, 5, 3, 0. After the fourth dequeue: o_empty=1, o_valid=0, o_data=0.
- QUEUE_SIZE=5, fill with 1..5, sixth enqueue of 7 → o_err pulse, o_count stays 5, value 7 never appears at the head.
- Dequeue on empty → o_err pulse, o_count 0. Replace with 0x00AA on empty → o_count=1, o_data=0x00AA.
- MIN_HEAP=1, enqueue 4, 2, 8, then replace with 6 → head 2 replaced; settles to head 4; o_count stays 3.
- Assert i_RST mid-stream with the tree holding 3 entries → next cycle all outputs at reset values. A subsequent enqueue of 1 gives o_data=1.
